// File: rtl/vec_pkg.sv
// Shared types and constants for the vector store sequencer.
// Lane geometry, FSM encoding and a one-hot helper used by the top.
package vec_pkg;

  localparam int unsigned LANES       = 4;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned ADDR_STRIDE = 4;
  localparam int unsigned IDX_W       = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    FINISH = 2'd2
  } vss_state_t;

  typedef logic [LANES-1:0] lane_mask_t;

  function automatic lane_mask_t lane_bit(input logic [IDX_W-1:0] idx);
    lane_bit = lane_mask_t'(1) << idx;
  endfunction

endpackage

// File: rtl/lane_pick.sv
// Lowest-set-bit priority encoder over a lane mask.
// any_o is low when no lane is enabled; idx_o is then 0.
module lane_pick
  import vec_pkg::*;
(
  input  logic [LANES-1:0] mask_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o = IDX_W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vec_store_sequencer.sv
// Serialises a masked 4-lane vector store into one memory write per cycle,
// stalling the upstream pipeline until every enabled lane is written.
module vec_store_sequencer
  import vec_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_W-1:0]       req_base_addr_i,
  input  logic [LANES*DATA_W-1:0] req_data_i,
  input  logic [LANES-1:0]        req_mask_i,
  output logic                    mem_we_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [DATA_W-1:0]       mem_wdata_o,
  input  logic                    mem_ack_i,
  output logic                    stop_o,
  output logic                    done_o
);

  vss_state_t                     state_q, state_d;
  lane_mask_t                     mask_q, mask_d;
  logic [LANES-1:0][DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]              base_q, base_d;

  logic [IDX_W-1:0]               cur_idx;
  logic                           cur_any;
  lane_mask_t                     mask_rem;

  lane_pick u_lane_pick (
    .mask_i (mask_q),
    .idx_o  (cur_idx),
    .any_o  (cur_any)
  );

  assign mask_rem = mask_q & ~lane_bit(cur_idx);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = (req_mask_i != '0) ? ISSUE : FINISH;
        end
      end
      ISSUE: begin
        if (mem_ack_i && (mask_rem == '0)) begin
          state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mask_q <= '0;
      data_q <= '0;
      base_q <= '0;
    end else begin
      mask_q <= mask_d;
      data_q <= data_d;
      base_q <= base_d;
    end
  end

  // Request fields are captured only on acceptance; the mask then drains per ack.
  always_comb begin
    mask_d = mask_q;
    data_d = data_q;
    base_d = base_q;
    if (state_q == IDLE && req_valid_i) begin
      mask_d = req_mask_i;
      data_d = req_data_i;
      base_d = req_base_addr_i;
    end else if (state_q == ISSUE && mem_ack_i) begin
      mask_d = mask_rem;
    end
  end

  always_comb begin
    req_ready_o = (state_q == IDLE);
    stop_o      = (state_q != IDLE);
    done_o      = (state_q == FINISH);
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (state_q == ISSUE && cur_any) begin
      mem_we_o    = 1'b1;
      mem_addr_o  = base_q + ADDR_W'(cur_idx) * ADDR_W'(ADDR_STRIDE);
      mem_wdata_o = data_q[cur_idx];
    end
  end

endmodule

// File: tb/tb_vec_store_sequencer.sv
// Directed bench for vec_store_sequencer: reset, full/sparse/empty masks,
// memory back-pressure, address wrap and reset during an active store.
module tb_vec_store_sequencer;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_base_addr;
  logic [127:0]  req_data;
  logic [3:0]    req_mask;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic          stop;
  logic          done;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] D0 = 32'h1000_00A0;
  localparam logic [31:0] D1 = 32'h2000_00B1;
  localparam logic [31:0] D2 = 32'h3000_00C2;
  localparam logic [31:0] D3 = 32'h4000_00D3;
  localparam logic [127:0] DVEC = {D3, D2, D1, D0};

  always #5 clk = ~clk;

  vec_store_sequencer dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_base_addr_i (req_base_addr),
    .req_data_i      (req_data),
    .req_mask_i      (req_mask),
    .mem_we_o        (mem_we),
    .mem_addr_o      (mem_addr),
    .mem_wdata_o     (mem_wdata),
    .mem_ack_i       (mem_ack),
    .stop_o          (stop),
    .done_o          (done)
  );

  // Present a request at a falling edge; returns at the first negedge after acceptance.
  task automatic drive_req(input logic [31:0] b, input logic [127:0] d, input logic [3:0] m);
    req_valid     = 1'b1;
    req_base_addr = b;
    req_data      = d;
    req_mask      = m;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = 1'b0;
    req_base_addr = '0;
    req_data = '0;
    req_mask = '0;
    mem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ready, mem_we, stop, done} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=1000", {req_ready, mem_we, stop, done});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_bus got=%h exp=0", {mem_addr, mem_wdata});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    mem_ack = 1'b1;
    drive_req(32'h100, DVEC, 4'b1111);
    @(negedge clk);  // lane 0 acked, now on lane 1
    checks++;
    if (mem_addr !== 32'h104) begin
      failures++;
      $display("FAIL rstmid_pre addr got=%h exp=00000104", mem_addr);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({mem_we, stop} !== 2'b00) begin
      failures++;
      $display("FAIL rstmid_async we_stop got=%b exp=00", {mem_we, stop});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_ready got=%b exp=1", req_ready);
    end
    @(negedge clk);
    drive_req(32'h40, DVEC, 4'b1111);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h40, D0}) begin
      failures++;
      $display("FAIL rstmid_restart got=%b/%h/%h exp=1/00000040/%h", mem_we, mem_addr, mem_wdata,
               D0);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_full;
    logic [31:0] ea[4];
    logic [31:0] ed[4];
    ea = '{32'h100, 32'h104, 32'h108, 32'h10C};
    ed = '{D0, D1, D2, D3};
    mem_ack = 1'b1;
    drive_req(32'h100, DVEC, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({mem_we, stop, done, mem_addr, mem_wdata} !== {3'b110, ea[i], ed[i]}) begin
        failures++;
        $display("FAIL full_lane%0d got we=%b stop=%b done=%b addr=%h data=%h exp 1/1/0/%h/%h", i,
                 mem_we, stop, done, mem_addr, mem_wdata, ea[i], ed[i]);
      end
      @(negedge clk);
    end
    checks++;
    if ({mem_we, stop, done} !== 3'b011) begin
      failures++;
      $display("FAIL full_done got we_stop_done=%b exp=011", {mem_we, stop, done});
    end
    @(negedge clk);
    checks++;
    if ({req_ready, stop, done} !== 3'b100) begin
      failures++;
      $display("FAIL full_idle got ready_stop_done=%b exp=100", {req_ready, stop, done});
    end
  endtask

  task automatic test_sparse;
    mem_ack = 1'b1;
    drive_req(32'h20, DVEC, 4'b1010);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h24, D1}) begin
      failures++;
      $display("FAIL sparse_w0 got=%b/%h/%h exp=1/00000024/%h", mem_we, mem_addr, mem_wdata, D1);
    end
    @(negedge clk);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h2C, D3}) begin
      failures++;
      $display("FAIL sparse_w1 got=%b/%h/%h exp=1/0000002c/%h", mem_we, mem_addr, mem_wdata, D3);
    end
    @(negedge clk);
    checks++;
    if ({mem_we, done, mem_addr} !== {2'b01, 32'h0}) begin
      failures++;
      $display("FAIL sparse_done got we=%b done=%b addr=%h exp 0/1/0", mem_we, done, mem_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_empty;
    mem_ack = 1'b1;
    drive_req(32'h500, DVEC, 4'b0000);
    checks++;
    if ({mem_we, stop, done, req_ready} !== 4'b0110) begin
      failures++;
      $display("FAIL empty_done got we_stop_done_ready=%b exp=0110", {mem_we, stop, done, req_ready});
    end
    @(negedge clk);
    checks++;
    if ({mem_we, stop, done, req_ready} !== 4'b0001) begin
      failures++;
      $display("FAIL empty_idle got we_stop_done_ready=%b exp=0001", {mem_we, stop, done, req_ready});
    end
  endtask

  task automatic test_backpressure;
    mem_ack = 1'b0;
    drive_req(32'h300, DVEC, 4'b0011);
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if ({mem_we, req_ready, mem_addr, mem_wdata} !== {2'b10, 32'h300, D0}) begin
        failures++;
        $display("FAIL bp_hold%0d got we=%b ready=%b addr=%h data=%h exp 1/0/00000300/%h", c,
                 mem_we, req_ready, mem_addr, mem_wdata, D0);
      end
      // Stray requests while busy must not be taken.
      if (c == 2) begin
        req_valid = 1'b1;
        req_base_addr = 32'h999;
        req_mask = 4'b1111;
      end else begin
        req_valid = 1'b0;
      end
      if (c == 4) mem_ack = 1'b1;
      @(negedge clk);
    end
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h304, D1}) begin
      failures++;
      $display("FAIL bp_lane1 got=%b/%h/%h exp=1/00000304/%h", mem_we, mem_addr, mem_wdata, D1);
    end
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if ({mem_we, done} !== 2'b01) begin
      failures++;
      $display("FAIL bp_done got we_done=%b exp=01", {mem_we, done});
    end
    @(negedge clk);
    checks++;
    if ({mem_we, stop, done} !== 3'b000) begin
      failures++;
      $display("FAIL bp_noqueue got we_stop_done=%b exp=000", {mem_we, stop, done});
    end
  endtask

  task automatic test_wrap;
    mem_ack = 1'b1;
    drive_req(32'hFFFF_FFFC, DVEC, 4'b0011);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'hFFFF_FFFC, D0}) begin
      failures++;
      $display("FAIL wrap_w0 got=%b/%h/%h exp=1/fffffffc/%h", mem_we, mem_addr, mem_wdata, D0);
    end
    @(negedge clk);
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h0, D1}) begin
      failures++;
      $display("FAIL wrap_w1 got=%b/%h/%h exp=1/00000000/%h", mem_we, mem_addr, mem_wdata, D1);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL wrap_done got=%b exp=1", done);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_full();
    test_sparse();
    test_empty();
    test_backpressure();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
